// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, ALU opcode constants and widths for alu_op_arbiter
package alu_arb_pkg;
  localparam int DW = 32;
  localparam int NUM_OPS = 5;
  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_op_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching req from ptr upward with wrap
//   req  in  NREQ  request vector
//   ptr  in  PW    highest-priority index
//   gnt  out NREQ  one-hot grant (zero when no request)
//   idx  out PW    encoded grant index
//   any  out 1     some request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  int j;
  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        gnt = NREQ'(1) << j;
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: round-robin sharing of one ALU32 among NREQ requesters
//   clk, rst_n (async, active-low)
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request channel (packed)
//   resp_valid/resp_ready/resp_data/resp_err : per-requester response, shared data bus
//   alu_op/alu_a/alu_b/alu_start/alu_result : ALU interface
//   busy : transaction in progress
//   Macro ALU_ARB_OPCHECK_EN: opcodes >= NUM_OPS bypass the ALU and return resp_err=1.
module alu_op_arbiter #(
  parameter int NREQ = 4,
  parameter int ALU_LAT = 1,
  parameter int NUM_OPS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [2:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic              alu_start,
  input  logic [31:0]       alu_result,
  output logic              busy
);
  import alu_arb_pkg::*;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif
  state_t state;
  logic [PW-1:0] ptr, g_q, gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic any;
  logic [3:0] cnt;
  logic [2:0] op_q, sel_op;
  logic [DW-1:0] a_q, b_q, res_q, sel_a, sel_b;
  logic start, err, bad;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt_oh),
    .idx(gnt_idx),
    .any(any)
  );
  assign sel_op = req_op[3*gnt_idx +: 3];
  assign sel_a = req_a[32*gnt_idx +: 32];
  assign sel_b = req_b[32*gnt_idx +: 32];
  assign bad = OPCHK && (32'(sel_op) >= NUM_OPS);
  assign req_ready = (state == S_IDLE) ? gnt_oh : '0;
  assign resp_valid = (state == S_RESP) ? NREQ'(1) << g_q : '0;
  assign resp_data = res_q;
  assign resp_err = (state == S_RESP) && err;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_start = start;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr <= '0;
      g_q <= '0;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      start <= 1'b0;
      err <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE:
          if (any) begin
            g_q <= gnt_idx;
            err <= bad;
            // Illegal ops never reach the ALU, so its op/operand latches keep their old values.
            if (bad) begin
              res_q <= '0;
              state <= S_RESP;
            end else begin
              op_q <= sel_op;
              a_q <= sel_a;
              b_q <= sel_b;
              cnt <= 4'(ALU_LAT - 1);
              start <= 1'b1;
              state <= S_EXEC;
            end
          end
        S_EXEC:
          if (cnt == 4'd0) begin
            res_q <= alu_result;
            state <= S_RESP;
          end else cnt <= cnt - 4'd1;
        S_RESP:
          if (resp_ready[g_q]) begin
            ptr <= (32'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_arbiter.sv
// tb_alu_op_arbiter: randomized self-checking bench with a transaction-level reference model
module tb_alu_op_arbiter;
  import alu_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int ALU_LAT = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic [NREQ-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [3*NREQ-1:0] req_op = '0;
  logic [32*NREQ-1:0] req_a = '0, req_b = '0;
  logic [31:0] resp_data, alu_a, alu_b, alu_result;
  logic resp_err, alu_start, busy;
  logic [2:0] alu_op;
  int checks = 0, errors = 0;
  int ptr_m = 0;
  logic [2:0] last_op = 3'd0;
  int age;
  alu_op_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .NUM_OPS(NUM_OPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .alu_result(alu_result),
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_0: return a + b;
      OP_1: return a - b;
      OP_2: return a & b;
      OP_3: return a | b;
      OP_4: return a ^ b;
      default: return a ^ ~b;
    endcase
  endfunction
  // Stand-in ALU: the result is only valid in the cycle that ends ALU_LAT cycles after launch.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) age <= 0;
    else if (alu_start) age <= 1;
    else if (age > 0) age <= age + 1;
  assign alu_result = ((alu_start && ALU_LAT == 1) || (age > 0 && age == ALU_LAT - 1)) ?
                      alu_f(alu_op, alu_a, alu_b) : 32'hdeadbeef;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic randomize_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = 3'($urandom_range(0, 7));
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
    end
  endtask
  // One full transaction starting from IDLE, just after a clock edge.
  task automatic txn(input logic [NREQ-1:0] mask, input int hold);
    int g, n;
    logic [2:0] op;
    logic [31:0] a, b, exp;
    logic [NREQ-1:0] oh;
    bit bad;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && mask[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    oh = NREQ'(1) << g;
    op = req_op[3*g +: 3];
    a = req_a[32*g +: 32];
    b = req_b[32*g +: 32];
`ifdef ALU_ARB_OPCHECK_EN
    bad = int'(op) >= NUM_OPS;
`else
    bad = 1'b0;
`endif
    exp = bad ? 32'd0 : alu_f(op, a, b);
    req_valid = mask;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 0);
    @(posedge clk); #1;
    req_valid = '1;
    #1;
    chk("req_ready_busy", 32'(req_ready), 0);
    chk("busy_active", 32'(busy), 1);
    n = 0;
    if (bad) begin
      chk("start_skipped", 32'(alu_start), 0);
      chk("alu_op_kept", 32'(alu_op), 32'(last_op));
    end else begin
      chk("alu_start", 32'(alu_start), 1);
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, b);
      last_op = op;
      while (resp_valid == '0 && n < ALU_LAT + 4) begin
        @(posedge clk); #2;
        n++;
      end
    end
    chk("accept_to_resp_latency", 32'(n + 1), bad ? 32'd1 : 32'(ALU_LAT + 1));
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_data", resp_data, exp);
    chk("resp_err", 32'(resp_err), 32'(bad));
    resp_ready = ~oh;
    repeat (hold) begin
      @(posedge clk); #2;
      chk("hold_resp_valid", 32'(resp_valid), 32'(oh));
      chk("hold_resp_data", resp_data, exp);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    resp_ready = oh;
    req_valid = '0;
    @(posedge clk); #1;
    resp_ready = '0;
    chk("busy_after_resp", 32'(busy), 0);
    chk("resp_valid_after", 32'(resp_valid), 0);
    ptr_m = (g + 1) % NREQ;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_start", 32'(alu_start), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    @(posedge clk); #1;
    // Fairness: all requesting, grants must rotate 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      randomize_reqs();
      for (int r = 0; r < NREQ; r++) req_op[3*r +: 3] = 3'($urandom_range(0, NUM_OPS - 1));
      txn(4'hf, 0);
    end
    // Single op: requester 1, op 3, a=5, b=7
    req_op[5:3] = 3'd3;
    req_a[63:32] = 32'd5;
    req_b[63:32] = 32'd7;
    txn(4'b0010, 0);
    // Backpressure on requester 2 for 10 cycles
    randomize_reqs();
    req_op[8:6] = OP_1;
    txn(4'b0100, 10);
    // Illegal opcode handling
    randomize_reqs();
    req_op[2:0] = 3'b110;
    txn(4'b0001, 2);
    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      randomize_reqs();
      txn(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
    // Reset in the middle of EXEC: the request must vanish and arbitration restart at 0
    randomize_reqs();
    req_op[11:9] = OP_2;
    req_valid = 4'b1000;
    @(posedge clk); #1;
    req_valid = '0;
    chk("mid_exec_busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1;
    ptr_m = 0;
    last_op = 3'd0;
    resp_ready = '1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("aborted_no_resp", 32'(resp_valid), 0);
    end
    resp_ready = '0;
    randomize_reqs();
    txn(4'hf, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
